// File: rtl/core_if_imem_rsp.sv
// core_if_imem_rsp: loadable instruction memory with a fixed-latency fetch pipeline and in-order response FIFO
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_imem_rsp #(
    parameter int                        ADDR_WIDTH = 10,
    parameter logic [`CORE_PC_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                        LATENCY    = 2,
    parameter int                        FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [`CORE_PC_WIDTH-1:0]   req_pc,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [`CORE_INST_WIDTH-1:0] rsp_inst,
    output logic [`CORE_PC_WIDTH-1:0]   rsp_pc,
    output logic                        rsp_err,
    input  logic                        flush,
    input  logic                        load_wen,
    input  logic [ADDR_WIDTH-1:0]       load_addr,
    input  logic [31:0]                 load_data
);
    localparam int PCW = `CORE_PC_WIDTH;
    localparam int IW  = `CORE_INST_WIDTH;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int S   = LATENCY - 1;

    typedef struct packed {
        logic [IW-1:0]  inst;
        logic [PCW-1:0] pc;
        logic           err;
    } entry_t;

    logic [31:0]    mem [2**ADDR_WIDTH];
    logic [PCW-1:0] off;
    logic           acc, push, pop;
    entry_t         in_e, push_e, head;
    int unsigned    inflight;
    entry_t         fifo_q [FIFO_DEPTH];
    entry_t         fifo_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Decode the fetch address: misaligned or outside the window faults with zero data
    always_comb begin
        off         = req_pc - BASE_ADDR;
        in_e.pc     = req_pc;
        in_e.err    = (req_pc[1:0] != 2'b00) || (req_pc < BASE_ADDR) || ((off >> (ADDR_WIDTH + 2)) != '0);
        in_e.inst   = in_e.err ? '0 : IW'(mem[off[ADDR_WIDTH+1:2]]);
        acc         = req_valid && req_ready;
        head        = fifo_q[rd_q];
        rsp_valid   = !flush && (cnt_q != '0);
        pop         = rsp_valid && rsp_ready;
        rsp_inst    = rsp_valid ? head.inst : '0;
        rsp_pc      = rsp_valid ? head.pc : '0;
        rsp_err     = rsp_valid && head.err;
        req_ready   = rst_n && !flush && ((inflight + 32'(cnt_q)) < 32'(FIFO_DEPTH));
    end

    // Program-load port; contents survive reset and a same-edge fetch sees the old word
    always_ff @(posedge clk) begin
        if (load_wen) mem[load_addr] <= load_data;
    end

    if (S == 0) begin : g_direct
        assign push   = acc;
        assign push_e = in_e;
        assign inflight = 0;
    end else begin : g_pipe
        entry_t     stg_q [S];
        entry_t     stg_d [S];
        logic [S-1:0] stg_v_q, stg_v_d;

        // Accepted fetches advance one stage per edge; the FIFO always has room, so no stall
        always_comb begin
            stg_v_d[0] = acc;
            stg_d[0]   = in_e;
            for (int i = 1; i < S; i++) begin
                stg_v_d[i] = stg_v_q[i-1];
                stg_d[i]   = stg_q[i-1];
            end
            if (flush) stg_v_d = '0;
        end

        // Count occupied stages for the outstanding limit
        always_comb begin
            inflight = 0;
            for (int i = 0; i < S; i++) inflight = inflight + 32'(stg_v_q[i]);
        end

        // Stage registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_v_q <= '0;
                stg_q   <= '{default: '0};
            end else begin
                stg_v_q <= stg_v_d;
                stg_q   <= stg_d;
            end
        end

        assign push   = stg_v_q[S-1] && !flush;
        assign push_e = stg_q[S-1];
    end

    // FIFO bookkeeping; flush empties it in one edge
    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_q] = push_e;
        wr_d  = flush ? '0 : wr_q + PW'(push);
        rd_d  = flush ? '0 : rd_q + PW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    // FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            fifo_q <= fifo_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_core_if_imem_rsp.sv
// tb_core_if_imem_rsp: directed stimulus checked against a queue-based response model
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module tb_core_if_imem_rsp;
    localparam int AW = 10;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 1, flush = 0, load_wen = 0;
    logic [31:0] req_pc = 0, load_data = 0;
    logic [AW-1:0] load_addr = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_inst, rsp_pc;
    int          checks = 0, failures = 0;

    core_if_imem_rsp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
        .rsp_err(rsp_err), .flush(flush), .load_wen(load_wen), .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [1024];
    int          cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_valid();
        return rst_n && !flush && q.size() > 0 && q[0].due <= cyc;
    endfunction

    function automatic logic ref_ready();
        return rst_n && !flush && q.size() < D;
    endfunction

    function automatic rsp_t fetch(logic [31:0] pc);
        rsp_t r;
        logic [32:0] lim;
        lim   = {1'b0, BASE} + 33'(4 << AW);
        r.pc  = pc;
        r.err = (pc[1:0] != 2'b00) || (pc < BASE) || ({1'b0, pc} >= lim);
        r.inst = r.err ? 32'h0 : mm[10'((pc - BASE) >> 2)];
        r.due = 0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic v, r;
        rsp_t f;
        if (!rst_n) q.delete();
        else begin
            v = ref_valid();
            r = ref_ready();
            f = fetch(req_pc);
            cyc++;
            if (flush) q.delete();
            else begin
                if (v && rsp_ready) void'(q.pop_front());
                if (req_valid && r) begin
                    f.due = cyc + L - 1;
                    q.push_back(f);
                end
            end
            if (load_wen) mm[load_addr] = load_data;
        end
    end

    always @(negedge clk) begin
        chk("rsp_valid", 32'(rsp_valid), 32'(ref_valid()));
        chk("req_ready", 32'(req_ready), 32'(ref_ready()));
        if (ref_valid()) begin
            chk("rsp_pc", rsp_pc, q[0].pc);
            chk("rsp_inst", rsp_inst, q[0].inst);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end else if (!rst_n) begin
            chk("reset rsp_pc", rsp_pc, 0);
            chk("reset rsp_inst", rsp_inst, 0);
            chk("reset rsp_err", 32'(rsp_err), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, pops;
        logic a;
        logic [31:0] bad [3];
        bad = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC};
        repeat (2) tick();
        #1;
        chk("in reset req_ready", 32'(req_ready), 0);
        chk("in reset rsp_valid", 32'(rsp_valid), 0);
        rst_n = 1;
        #1;
        chk("after reset req_ready", 32'(req_ready), 1);
        for (int i = 0; i < 8; i++) begin
            load_wen  = 1;
            load_addr = 10'(i);
            load_data = (i == 0) ? 32'h0000_0093 : (i == 1) ? 32'h0010_0113 : 32'h1000_0000 + 32'(i);
            tick();
        end
        load_wen = 0;

        req_valid = 1;
        req_pc = BASE;
        tick();
        req_pc = BASE + 4;
        tick();
        req_valid = 0;
        #1;
        chk("b2b first valid", 32'(rsp_valid), 1);
        chk("b2b first inst", rsp_inst, 32'h0000_0093);
        chk("b2b first pc", rsp_pc, 32'h8000_0000);
        chk("b2b first err", 32'(rsp_err), 0);
        tick();
        #1;
        chk("b2b second inst", rsp_inst, 32'h0010_0113);
        chk("b2b second pc", rsp_pc, 32'h8000_0004);
        tick();
        #1;
        chk("b2b drained", 32'(rsp_valid), 0);

        rsp_ready = 0;
        req_valid = 1;
        req_pc = BASE + 8;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            a = req_ready;
            tick();
            if (a) begin
                acc++;
                req_pc = req_pc + 4;
            end
        end
        req_valid = 0;
        #1;
        chk("full accepted count", 32'(acc), 4);
        chk("full req_ready", 32'(req_ready), 0);
        rsp_ready = 1;
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            a = rsp_valid;
            tick();
            if (a) pops++;
        end
        #1;
        chk("drain response count", 32'(pops), 4);
        chk("drain req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 3; i++) begin
            req_valid = 1;
            req_pc = bad[i];
            tick();
            req_valid = 0;
            tick();
            #1;
            chk("fault valid", 32'(rsp_valid), 1);
            chk("fault err", 32'(rsp_err), 1);
            chk("fault inst", rsp_inst, 0);
            tick();
        end

        rsp_ready = 0;
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req_pc = BASE + 32'(4 * i);
            tick();
        end
        req_valid = 0;
        flush = 1;
        #1;
        chk("flush rsp_valid", 32'(rsp_valid), 0);
        chk("flush req_ready", 32'(req_ready), 0);
        tick();
        flush = 0;
        #1;
        chk("post flush rsp_valid", 32'(rsp_valid), 0);
        chk("post flush req_ready", 32'(req_ready), 1);
        rsp_ready = 1;
        repeat (2) tick();
        #1;
        chk("no stale after flush", 32'(rsp_valid), 0);
        req_valid = 1;
        req_pc = BASE + 4;
        tick();
        req_valid = 0;
        #1;
        chk("post flush early", 32'(rsp_valid), 0);
        tick();
        #1;
        chk("post flush valid", 32'(rsp_valid), 1);
        chk("post flush inst", rsp_inst, 32'h0010_0113);
        tick();

        load_wen = 1;
        load_addr = 10'd1;
        load_data = 32'hDEAD_BEEF;
        req_valid = 1;
        req_pc = BASE + 4;
        tick();
        load_wen = 0;
        req_valid = 0;
        tick();
        #1;
        chk("load same edge old data", rsp_inst, 32'h0010_0113);
        tick();
        req_valid = 1;
        tick();
        req_valid = 0;
        tick();
        #1;
        chk("load refetch new data", rsp_inst, 32'hDEAD_BEEF);
        tick();

        rsp_ready = 0;
        req_valid = 1;
        req_pc = BASE;
        tick();
        req_pc = BASE + 4;
        tick();
        req_valid = 0;
        tick();
        #1;
        chk("buffered before reset", 32'(rsp_valid), 1);
        #1;
        rst_n = 0;
        #1;
        chk("async reset rsp_valid", 32'(rsp_valid), 0);
        chk("async reset req_ready", 32'(req_ready), 0);
        chk("async reset rsp_inst", rsp_inst, 0);
        repeat (2) tick();
        rst_n = 1;
        rsp_ready = 1;
        #1;
        chk("release req_ready", 32'(req_ready), 1);
        chk("release rsp_valid", 32'(rsp_valid), 0);
        repeat (3) tick();
        #1;
        chk("no stale after reset", 32'(rsp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_if_imem_rsp.md
CORE_IF_IMEM_RSP -- requirements
Module: core_if_imem_rsp

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-index width; memory is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, SHALL set the byte address of word 0.
REQ-003 Parameter LATENCY, default 2, legal 1..4, SHALL set the accept-to-response latency in clock edges.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, SHALL set the response buffer depth.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  1  fetch request valid.
REQ-009 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-010 req_pc  input  `CORE_PC_WIDTH  fetch byte address.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-013 rsp_inst  output  `CORE_INST_WIDTH  fetched instruction.
REQ-014 rsp_pc  output  `CORE_PC_WIDTH  pc of the request answered.
REQ-015 rsp_err  output  1  access fault (misaligned or out of range).
REQ-016 flush  input  1  pipeline flush; discards all outstanding requests and responses.
REQ-017 load_wen  input  1  program-load write enable.
REQ-018 load_addr  input  ADDR_WIDTH  program-load word index.
REQ-019 load_data  input  32  program-load write data.

Function
REQ-020 Responses SHALL be returned in request order, one per accepted request.
REQ-021 With an empty FIFO and rsp_ready high, a request accepted at edge E0 SHALL produce rsp_valid high in the cycle following edge E(LATENCY-1), i.e. visible LATENCY-1 edges after E0, held until consumed.
REQ-022 outstanding = in-flight stage count + FIFO occupancy; req_ready SHALL be high iff outstanding < FIFO_DEPTH and flush is low, so the FIFO never overflows.
REQ-023 Read index = (req_pc - BASE_ADDR) >> 2, truncated to ADDR_WIDTH.
REQ-024 req_pc[1:0] != 0 SHALL yield rsp_err=1 and rsp_inst=32'h0000_0000.
REQ-025 req_pc < BASE_ADDR or req_pc >= BASE_ADDR + 4*2^ADDR_WIDTH SHALL yield rsp_err=1 and rsp_inst=0; no wrap-around aliasing.
REQ-026 rsp_inst, rsp_pc and rsp_err SHALL remain stable while rsp_valid && !rsp_ready.
REQ-027 FIFO full with rsp_ready low: req_ready low, in-flight stages advance into FIFO only as space permits; no response lost or duplicated.
REQ-028 Simultaneous FIFO push and pop at full or empty SHALL be supported with no bubble; occupancy unchanged.
REQ-029 flush high at an edge SHALL invalidate all in-flight stages and empty the FIFO; rsp_valid and req_ready are forced low in that cycle, so no handshake completes during it.
REQ-030 The first request accepted after flush falls SHALL be answered with LATENCY per REQ-021.
REQ-031 load_wen SHALL write load_data to word load_addr at the edge; a fetch of the same word at that edge returns the old data.
REQ-032 Memory contents SHALL NOT be reset; loads and fetches may overlap with no ordering interlock beyond REQ-031.

Reset
REQ-033 While rst_n is low: req_ready=0, rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_err=0, in-flight and FIFO state cleared.
REQ-034 First cycle after rst_n rises: req_ready=1; a reset asserted mid-operation discards all outstanding work with no response.

Verification (ADDR_WIDTH=10, BASE_ADDR=32'h8000_0000, LATENCY=2, FIFO_DEPTH=4)
REQ-035 Load word0=32'h0000_0093, word1=32'h0010_0113; fetch 0x8000_0000 then 0x8000_0004 back to back with rsp_ready=1 -> responses 0x00000093/pc 0x80000000 and 0x00100113/pc 0x80000004, one edge after each accept, err=0.
REQ-036 rsp_ready=0, issue requests continuously -> exactly 4 accepted, req_ready low; raise rsp_ready -> 4 in-order responses, then req_ready high.
REQ-037 Fetch 0x8000_0002 -> rsp_err=1, rsp_inst=0; fetch 0x8000_1000 -> rsp_err=1, rsp_inst=0; fetch 0x7FFF_FFFC -> rsp_err=1.
REQ-038 Three requests outstanding, pulse flush one cycle -> no responses for them; next request to 0x8000_0004 returns 0x00100113 with nominal latency.
REQ-039 load_wen to word 1 with 32'hDEAD_BEEF at same edge as a fetch of 0x8000_0004 -> response 0x00100113; refetch -> 0xDEADBEEF.
REQ-040 Drop rst_n asynchronously with 2 responses buffered -> rsp_valid and req_ready low immediately; after release, no stale responses appear.
